// File: rtl/jk_pkg.sv
// Shared mode encoding for the JK counter and anything that drives it.
package jk_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with true/complement outputs: 00 hold, 10 set, 01 clear, 11 toggle.
// Latency one clock; no flow control, updates every rising edge.
module jk_cell (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_j,
    input  logic i_k,
    output logic o_q,
    output logic o_q_n
);

    logic r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= 1'b0;
        end else begin
            case ({i_j, i_k})
                2'b10:   r_q <= 1'b1;
                2'b01:   r_q <= 1'b0;
                2'b11:   r_q <= ~r_q;
                default: r_q <= r_q;
            endcase
        end
    end

    // Complement derived from the single state bit so it can never disagree with q.
    assign o_q   = r_q;
    assign o_q_n = ~r_q;

endmodule

// File: rtl/jk_counter.sv
// Up/down/load modulo counter built from JK cells, with terminal-count and wrap pulse.
// Latency one clock from sampling edge to q; no flow control, en=0 holds the count.
module jk_counter
    import jk_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_q_n,
    output logic             o_tc,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_q_n;
    logic [WIDTH-1:0] w_d;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_wrap_evt;
    logic             r_wrap;

    assign w_at_max  = (w_q == MAX_VAL);
    assign w_at_zero = (w_q == '0);

    always_comb begin
        w_d        = w_q;
        w_wrap_evt = 1'b0;
        if (i_en) begin
            case (i_mode)
                MODE_UP: begin
                    if (!w_at_max) begin
                        w_d = w_q + ONE;
                    end else if (SATURATE == 0) begin
                        w_d        = '0;
                        w_wrap_evt = 1'b1;
                    end
                end
                MODE_DOWN: begin
                    if (!w_at_zero) begin
                        w_d = w_q - ONE;
                    end else if (SATURATE == 0) begin
                        w_d        = MAX_VAL;
                        w_wrap_evt = 1'b1;
                    end
                end
                MODE_LOAD: begin
                    // Out-of-range loads clamp so no illegal state is ever reachable.
                    w_d = (i_load_val > MAX_VAL) ? MAX_VAL : i_load_val;
                end
                default: w_d = w_q;
            endcase
        end
    end

    // Only bits that must change get a set/clear; everything else sees J=K=0.
    assign w_j = w_d & ~w_q;
    assign w_k = ~w_d & w_q;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        jk_cell u_cell (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_j     (w_j[gi]),
            .i_k     (w_k[gi]),
            .o_q     (w_q[gi]),
            .o_q_n   (w_q_n[gi])
        );
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap_evt;
        end
    end

    assign o_q    = w_q;
    assign o_q_n  = w_q_n;
    assign o_wrap = r_wrap;
    assign o_tc   = ((i_mode == MODE_UP) && w_at_max) || ((i_mode == MODE_DOWN) && w_at_zero);

endmodule
